// File: rtl/pc_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack_if
//  Description : Call/return bus between the control unit and the
//                return-address stack. The master issues push/pop and
//                clear_err; the slave reports top entry, occupancy and
//                sticky error flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_stack_if #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic [PC_W-1:0]   push_data;
    logic              clear_err;
    logic [PC_W-1:0]   top;
    logic [c_CNT_W-1:0] count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    // Control-unit side
    modport master (
        output push, pop, push_data, clear_err,
        input  top, count, empty, full, overflow, underflow
    );

    // Stack side
    modport slave (
        input  push, pop, push_data, clear_err,
        output top, count, empty, full, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack
//  Description : Parametrised LIFO of return addresses. Push on call, pop on
//                return; the top entry is visible combinationally from the
//                registered state, so the return cycle sees the address being
//                popped. Optional circular mode overwrites the oldest entry
//                when full. Sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_stack #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8,
    parameter int WRAP  = 0
) (
    input  wire         clk,
    input  wire         reset,
    pc_stack_if.slave   bus
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = $clog2(DEPTH);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    // Storage and state
    logic [PC_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_sp;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    // Derived pointers and next-state values
    logic [c_PTR_W-1:0] w_sp_inc;
    logic [c_PTR_W-1:0] w_sp_dec;
    logic               w_empty;
    logic               w_full;
    logic [c_PTR_W-1:0] w_sp_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_wr_en;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic               w_ovf_set;
    logic               w_unf_set;

    // Explicit modulo-DEPTH wrap so non-power-of-two depths stay in range
    assign w_sp_inc = (r_sp == c_PTR_LAST) ? '0 : r_sp + 1'b1;
    assign w_sp_dec = (r_sp == '0) ? c_PTR_LAST : r_sp - 1'b1;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_FULL);

    // Outputs depend only on registered state
    assign bus.top       = w_empty ? '0 : r_mem[w_sp_dec];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

    // Decode push/pop into pointer, count, write and error-set actions
    always_comb begin
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_sp;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;

        if (bus.push && bus.pop) begin
            if (!w_empty) begin
                // Call and return together: replace the top in place
                w_wr_en  = 1'b1;
                w_wr_idx = w_sp_dec;
            end else begin
                // Nothing to return from: behaves as a push, flags underflow
                w_wr_en     = 1'b1;
                w_sp_nxt    = w_sp_inc;
                w_count_nxt = c_CNT_W'(1);
                w_unf_set   = 1'b1;
            end
        end else if (bus.push) begin
            if (!w_full) begin
                w_wr_en     = 1'b1;
                w_sp_nxt    = w_sp_inc;
                w_count_nxt = r_count + 1'b1;
            end else begin
                w_ovf_set = 1'b1;
                if (WRAP != 0) begin
                    // Circular mode: slot at sp holds the oldest entry
                    w_wr_en  = 1'b1;
                    w_sp_nxt = w_sp_inc;
                end
            end
        end else if (bus.pop) begin
            if (!w_empty) begin
                w_sp_nxt    = w_sp_dec;
                w_count_nxt = r_count - 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end
    end

    // Pointer, count and sticky flags; a same-cycle error set beats clear_err
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clear_err);
            r_underflow <= w_unf_set | (r_underflow & ~bus.clear_err);
        end
    end

    // Entry storage; contents are not cleared by reset, but writes are held off
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_stack
//  Description : Self-checking bench. Four stack configurations share one
//                stimulus stream; each is compared every cycle against an
//                array-based LIFO model (oldest entry at index 0), plus
//                directed scenario checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_stack;
    localparam int c_N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [9:0] push_data;
    logic       clear_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_stack_if #(.PC_W(10), .DEPTH(8)) if0 ();
    pc_stack_if #(.PC_W(10), .DEPTH(4)) if1 ();
    pc_stack_if #(.PC_W(10), .DEPTH(4)) if2 ();
    pc_stack_if #(.PC_W(10), .DEPTH(5)) if3 ();

    pc_stack #(.PC_W(10), .DEPTH(8), .WRAP(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    pc_stack #(.PC_W(10), .DEPTH(4), .WRAP(0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    pc_stack #(.PC_W(10), .DEPTH(4), .WRAP(1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    pc_stack #(.PC_W(10), .DEPTH(5), .WRAP(1)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if0.push = push; assign if0.pop = pop; assign if0.push_data = push_data; assign if0.clear_err = clear_err;
    assign if1.push = push; assign if1.pop = pop; assign if1.push_data = push_data; assign if1.clear_err = clear_err;
    assign if2.push = push; assign if2.pop = pop; assign if2.push_data = push_data; assign if2.clear_err = clear_err;
    assign if3.push = push; assign if3.pop = pop; assign if3.push_data = push_data; assign if3.clear_err = clear_err;

    logic [9:0] o_top [c_N];
    int         o_cnt [c_N];
    logic       o_emp [c_N];
    logic       o_ful [c_N];
    logic       o_ovf [c_N];
    logic       o_unf [c_N];

    assign o_top[0] = if0.top; assign o_cnt[0] = int'(if0.count); assign o_emp[0] = if0.empty;
    assign o_ful[0] = if0.full; assign o_ovf[0] = if0.overflow; assign o_unf[0] = if0.underflow;
    assign o_top[1] = if1.top; assign o_cnt[1] = int'(if1.count); assign o_emp[1] = if1.empty;
    assign o_ful[1] = if1.full; assign o_ovf[1] = if1.overflow; assign o_unf[1] = if1.underflow;
    assign o_top[2] = if2.top; assign o_cnt[2] = int'(if2.count); assign o_emp[2] = if2.empty;
    assign o_ful[2] = if2.full; assign o_ovf[2] = if2.overflow; assign o_unf[2] = if2.underflow;
    assign o_top[3] = if3.top; assign o_cnt[3] = int'(if3.count); assign o_emp[3] = if3.empty;
    assign o_ful[3] = if3.full; assign o_ovf[3] = if3.overflow; assign o_unf[3] = if3.underflow;

    // Reference model: stk[k][0] is the oldest entry, stk[k][n-1] the top
    logic [9:0] m_stk [c_N][8];
    int         m_n   [c_N];
    logic       m_ovf [c_N];
    logic       m_unf [c_N];

    function automatic int dep_of(input int k);
        case (k)
            0: return 8;
            1: return 4;
            2: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic bit wrap_of(input int k);
        return (k >= 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input int k);
        bit ov_set = 0;
        bit un_set = 0;
        int d = dep_of(k);
        if (reset) begin
            m_n[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            return;
        end
        if (push && pop) begin
            if (m_n[k] > 0) m_stk[k][m_n[k]-1] = push_data;
            else begin m_stk[k][0] = push_data; m_n[k] = 1; un_set = 1; end
        end else if (push) begin
            if (m_n[k] < d) begin
                m_stk[k][m_n[k]] = push_data; m_n[k]++;
            end else begin
                ov_set = 1;
                if (wrap_of(k)) begin
                    for (int i = 0; i < d - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                    m_stk[k][d-1] = push_data;
                end
            end
        end else if (pop) begin
            if (m_n[k] > 0) m_n[k]--;
            else un_set = 1;
        end
        if (clear_err) begin m_ovf[k] = 0; m_unf[k] = 0; end
        if (ov_set) m_ovf[k] = 1;
        if (un_set) m_unf[k] = 1;
    endtask

    task automatic compare_all();
        for (int k = 0; k < c_N; k++) begin
            logic [9:0] et;
            et = (m_n[k] > 0) ? m_stk[k][m_n[k]-1] : 10'd0;
            check($sformatf("top[%0d]", k),       32'(o_top[k]), 32'(et));
            check($sformatf("count[%0d]", k),     32'(o_cnt[k]), 32'(m_n[k]));
            check($sformatf("empty[%0d]", k),     32'(o_emp[k]), 32'(m_n[k] == 0));
            check($sformatf("full[%0d]", k),      32'(o_ful[k]), 32'(m_n[k] == dep_of(k)));
            check($sformatf("overflow[%0d]", k),  32'(o_ovf[k]), 32'(m_ovf[k]));
            check($sformatf("underflow[%0d]", k), 32'(o_unf[k]), 32'(m_unf[k]));
        end
    endtask

    // One clock: drive at negedge, model updates at posedge, compare at next negedge
    task automatic step(input bit r, input bit pu, input bit po, input logic [9:0] d, input bit ce);
        reset = r; push = pu; pop = po; push_data = d; clear_err = ce;
        @(posedge clk);
        for (int k = 0; k < c_N; k++) model_apply(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();  step(1, 0, 0, 10'd0, 0); endtask
    task automatic do_push(input logic [9:0] d); step(0, 1, 0, d, 0); endtask
    task automatic do_pop();    step(0, 0, 1, 10'd0, 0); endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0; clear_err = 1'b0;
        for (int k = 0; k < c_N; k++) begin m_n[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; end
        @(negedge clk);
        do_reset();
        check("rst_top", 32'(o_top[0]), 32'h0);
        check("rst_empty", 32'(o_emp[0]), 32'h1);

        // Basic LIFO order
        do_push(10'h005); do_push(10'h1A0); do_push(10'h3FF);
        check("lifo_top", 32'(o_top[0]), 32'h3FF);
        check("lifo_cnt", 32'(o_cnt[0]), 32'd3);
        do_pop(); check("lifo_pop2", 32'(o_top[0]), 32'h1A0);
        do_pop(); check("lifo_pop3", 32'(o_top[0]), 32'h005);
        do_pop(); check("lifo_empty", 32'(o_emp[0]), 32'h1);
        check("lifo_top0", 32'(o_top[0]), 32'h0);

        // Full without wrap drops the push
        do_reset();
        for (int v = 1; v <= 4; v++) do_push(10'(v));
        check("nw_full", 32'(o_ful[1]), 32'h1);
        do_push(10'd5);
        check("nw_ovf", 32'(o_ovf[1]), 32'h1);
        check("nw_cnt", 32'(o_cnt[1]), 32'd4);
        check("nw_top", 32'(o_top[1]), 32'd4);
        for (int v = 4; v >= 1; v--) begin
            check("nw_pop", 32'(o_top[1]), 32'(v));
            do_pop();
        end

        // Wrap overwrites the oldest
        do_reset();
        for (int v = 1; v <= 6; v++) do_push(10'(v));
        check("w_cnt", 32'(o_cnt[2]), 32'd4);
        check("w_ovf", 32'(o_ovf[2]), 32'h1);
        for (int v = 6; v >= 3; v--) begin
            check("w_pop", 32'(o_top[2]), 32'(v));
            do_pop();
        end
        check("w_empty", 32'(o_emp[2]), 32'h1);

        // Empty pop and sticky clear precedence
        do_reset();
        do_pop();
        check("unf_set", 32'(o_unf[0]), 32'h1);
        check("unf_cnt", 32'(o_cnt[0]), 32'd0);
        step(0, 0, 1, 10'd0, 1);
        check("unf_setwins", 32'(o_unf[0]), 32'h1);
        step(0, 0, 0, 10'd0, 1);
        check("unf_clr", 32'(o_unf[0]), 32'h0);

        // Replace-top and push+pop on empty
        do_push(10'h010);
        step(0, 1, 1, 10'h020, 0);
        check("rep_cnt", 32'(o_cnt[0]), 32'd1);
        check("rep_top", 32'(o_top[0]), 32'h020);
        do_pop();
        step(0, 1, 1, 10'h030, 0);
        check("pp_cnt", 32'(o_cnt[0]), 32'd1);
        check("pp_top", 32'(o_top[0]), 32'h030);
        check("pp_unf", 32'(o_unf[0]), 32'h1);

        // Non-power-of-two depth with wrap
        do_reset();
        for (int v = 1; v <= 12; v++) do_push(10'(v));
        for (int v = 12; v >= 8; v--) begin
            check("d5_pop", 32'(o_top[3]), 32'(v));
            do_pop();
        end
        do_push(10'd1); do_push(10'd2);
        step(1, 1, 0, 10'd3, 0);
        check("mid_rst_cnt", 32'(o_cnt[3]), 32'd0);
        check("mid_rst_top", 32'(o_top[3]), 32'h0);
        check("mid_rst_ovf", 32'(o_ovf[3]), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            step($urandom_range(0, 99) == 0,
                 (sel < 5) || (sel == 9),
                 (sel >= 4) && (sel < 9),
                 10'($urandom),
                 $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
